code_check: RTL and testbench

Sequence checker at the receive end of the incrementing code-generator link. Samples the 8-bit counter stream on qualified cycles and acquires lock onto the +1 (mod 2^DATA_W) sequence. Once locked, it flags and counts every sample that breaks the sequence, and drops lock after repeated misses. Used in bring-up and loopback to confirm the generator-to-sink path end to end.

---
 rtl/code_pkg.sv | 16 +
 rtl/sat_counter.sv | 27 ++
 rtl/code_check.sv | 118 +++++++++++
 tb/tb_code_check.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// Shared definitions for the incrementing code link: checker FSM states and
// default link parameters used by both the generator and the checker side.
package code_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCK
    } state_t;

    localparam int DATA_W   = 8;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; clear takes priority over
// increment, and the count holds once it reaches all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/code_check.sv
// Receive-side checker for the incrementing code stream: acquires lock on the
// +1 sequence, then flags and counts every sample that breaks it.
module code_check #(
    parameter int DATA_W   = code_pkg::DATA_W,
    parameter int LOCK_CNT = code_pkg::LOCK_CNT,
    parameter int LOSS_CNT = code_pkg::LOSS_CNT,
    parameter int ERR_W    = code_pkg::ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_locked,
    output logic              o_err_pulse,
    output logic [ERR_W-1:0]  o_err_cnt,
    output logic [DATA_W-1:0] o_expected
);

    import code_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_expected;
    logic [DATA_W-1:0] w_expected_next;
    logic [3:0]        r_run;
    logic [3:0]        w_run_next;
    logic [3:0]        r_miss;
    logic [3:0]        w_miss_next;
    logic              r_locked;
    logic              r_err_pulse;
    logic              w_err;
    logic              w_match;

    assign w_match = (i_in_data == r_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_expected  <= '0;
            r_run       <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_expected  <= w_expected_next;
            r_run       <= w_run_next;
            r_miss      <= w_miss_next;
            r_locked    <= (w_state_next == LOCK);
            r_err_pulse <= w_err;
        end
    end

    // Invalid cycles leave everything untouched; there is deliberately no timeout.
    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_run_next      = r_run;
        w_miss_next     = r_miss;
        w_err           = 1'b0;
        if (i_in_valid) begin
            case (r_state)
                HUNT: begin
                    w_expected_next = i_in_data + 1'b1;
                    w_run_next      = 4'd1;
                    w_state_next    = SYNC;
                end
                SYNC: begin
                    if (w_match) begin
                        w_expected_next = r_expected + 1'b1;
                        w_run_next      = r_run + 4'd1;
                        if ((r_run + 4'd1) == 4'(LOCK_CNT)) begin
                            w_state_next = LOCK;
                            w_miss_next  = 4'd0;
                        end
                    end else begin
                        w_expected_next = i_in_data + 1'b1;
                        w_run_next      = 4'd1;
                    end
                end
                LOCK: begin
                    // A corrupt sample still consumes one slot of the sequence.
                    w_expected_next = r_expected + 1'b1;
                    if (w_match) begin
                        w_miss_next = 4'd0;
                    end else begin
                        w_err       = 1'b1;
                        w_miss_next = r_miss + 4'd1;
                        if ((r_miss + 4'd1) == 4'(LOSS_CNT)) begin
                            w_state_next = HUNT;
                            w_run_next   = 4'd0;
                            w_miss_next  = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_err),
        .i_clr   (i_clr),
        .o_count (o_err_cnt)
    );

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_expected  = r_expected;

endmodule

// File: tb/tb_code_check.sv
// Self-checking bench for code_check: a directed vector table for the main
// sequences plus hand-written saturation, clear and async-reset cases.
module tb_code_check;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        inValid;
    logic [7:0]  inData;
    logic        locked;
    logic        errPulse;
    logic [15:0] errCnt;
    logic [7:0]  expected;
    logic        locked4;
    logic        errPulse4;
    logic [3:0]  errCnt4;
    logic [7:0]  expected4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        doRst;
        logic        valid;
        logic [7:0]  data;
        logic        clr;
        logic        expLocked;
        logic        expPulse;
        logic [15:0] expCnt;
        logic [7:0]  expExp;
    } vec_t;

    vec_t vecs[$];

    code_check dut (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (clr),
        .i_in_valid  (inValid),
        .i_in_data   (inData),
        .o_locked    (locked),
        .o_err_pulse (errPulse),
        .o_err_cnt   (errCnt),
        .o_expected  (expected)
    );

    code_check #(
        .ERR_W (4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (clr),
        .i_in_valid  (inValid),
        .i_in_data   (inData),
        .o_locked    (locked4),
        .o_err_pulse (errPulse4),
        .o_err_cnt   (errCnt4),
        .o_expected  (expected4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic doRst, input logic valid, input logic [7:0] data,
                          input logic c, input logic eL, input logic eP,
                          input logic [15:0] eC, input logic [7:0] eE);
        vec_t v;
        v.doRst = doRst; v.valid = valid; v.data = data; v.clr = c;
        v.expLocked = eL; v.expPulse = eP; v.expCnt = eC; v.expExp = eE;
        vecs.push_back(v);
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eL, input logic eP,
                               input logic [15:0] eC, input logic [7:0] eE);
        checkVal({tag, " locked"},   32'(locked),   32'(eL));
        checkVal({tag, " err_pulse"}, 32'(errPulse), 32'(eP));
        checkVal({tag, " err_cnt"},  32'(errCnt),   32'(eC));
        checkVal({tag, " expected"}, 32'(expected), 32'(eE));
    endtask

    // Drive one cycle's inputs, clock it in, and land 1 time unit after the edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic c);
        inValid = valid;
        inData  = data;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] mExp;

    initial begin
        rst = 1'b1; clr = 1'b0; inValid = 1'b0; inData = 8'd0;
        #12;
        checkOutput("reset", 1'b0, 1'b0, 16'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        // Lock from 0..3, then lose it with three bad samples and relock on 50..53.
        addVec(0, 1, 8'd0,   0, 0, 0, 16'd0, 8'd1);
        addVec(0, 1, 8'd1,   0, 0, 0, 16'd0, 8'd2);
        addVec(0, 1, 8'd2,   0, 0, 0, 16'd0, 8'd3);
        addVec(0, 1, 8'd3,   0, 1, 0, 16'd0, 8'd4);
        addVec(0, 1, 8'd7,   0, 1, 1, 16'd1, 8'd5);
        addVec(0, 1, 8'd7,   0, 1, 1, 16'd2, 8'd6);
        addVec(0, 1, 8'd7,   0, 0, 1, 16'd3, 8'd7);
        addVec(0, 1, 8'd50,  0, 0, 0, 16'd3, 8'd51);
        addVec(0, 1, 8'd51,  0, 0, 0, 16'd3, 8'd52);
        addVec(0, 1, 8'd52,  0, 0, 0, 16'd3, 8'd53);
        addVec(0, 1, 8'd53,  0, 1, 0, 16'd3, 8'd54);
        // Lock at 249..252, then run across the 255 -> 0 wrap.
        addVec(1, 1, 8'd249, 0, 0, 0, 16'd0, 8'd250);
        addVec(0, 1, 8'd250, 0, 0, 0, 16'd0, 8'd251);
        addVec(0, 1, 8'd251, 0, 0, 0, 16'd0, 8'd252);
        addVec(0, 1, 8'd252, 0, 1, 0, 16'd0, 8'd253);
        addVec(0, 1, 8'd253, 0, 1, 0, 16'd0, 8'd254);
        addVec(0, 1, 8'd254, 0, 1, 0, 16'd0, 8'd255);
        addVec(0, 1, 8'd255, 0, 1, 0, 16'd0, 8'd0);
        addVec(0, 1, 8'd0,   0, 1, 0, 16'd0, 8'd1);
        addVec(0, 1, 8'd1,   0, 1, 0, 16'd0, 8'd2);
        // Single corrupt sample while locked at expected=20.
        addVec(1, 1, 8'd16,  0, 0, 0, 16'd0, 8'd17);
        addVec(0, 1, 8'd17,  0, 0, 0, 16'd0, 8'd18);
        addVec(0, 1, 8'd18,  0, 0, 0, 16'd0, 8'd19);
        addVec(0, 1, 8'd19,  0, 1, 0, 16'd0, 8'd20);
        addVec(0, 1, 8'd99,  0, 1, 1, 16'd1, 8'd21);
        addVec(0, 1, 8'd21,  0, 1, 0, 16'd1, 8'd22);
        addVec(0, 1, 8'd22,  0, 1, 0, 16'd1, 8'd23);
        // Reseed in SYNC with idle gaps carrying junk data.
        addVec(1, 1, 8'd5,   0, 0, 0, 16'd0, 8'd6);
        addVec(0, 0, 8'd77,  0, 0, 0, 16'd0, 8'd6);
        addVec(0, 1, 8'd6,   0, 0, 0, 16'd0, 8'd7);
        addVec(0, 0, 8'd7,   0, 0, 0, 16'd0, 8'd7);
        addVec(0, 1, 8'd9,   0, 0, 0, 16'd0, 8'd10);
        addVec(0, 0, 8'd200, 0, 0, 0, 16'd0, 8'd10);
        addVec(0, 1, 8'd10,  0, 0, 0, 16'd0, 8'd11);
        addVec(0, 1, 8'd11,  0, 0, 0, 16'd0, 8'd12);
        addVec(0, 0, 8'd12,  0, 0, 0, 16'd0, 8'd12);
        addVec(0, 1, 8'd12,  0, 1, 0, 16'd0, 8'd13);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doRst) pulseReset();
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].expLocked, vecs[i].expPulse,
                        vecs[i].expCnt, vecs[i].expExp);
        end

        // Saturation: 20 mismatches, each followed by a match so lock is held.
        mExp = 8'd13;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, mExp + 8'd128, 1'b0);
            mExp = mExp + 8'd1;
            checkVal($sformatf("sat%0d pulse", i), 32'(errPulse), 32'd1);
            applyStimulus(1'b1, mExp, 1'b0);
            mExp = mExp + 8'd1;
        end
        checkVal("sat err_cnt4", 32'(errCnt4), 32'd15);
        checkVal("sat err_cnt16", 32'(errCnt), 32'd20);
        checkVal("sat locked", 32'(locked), 32'd1);
        checkVal("sat expected", 32'(expected), 32'(mExp));

        // Clear coincident with a mismatch: clear wins, pulse still fires.
        applyStimulus(1'b1, mExp + 8'd5, 1'b1);
        mExp = mExp + 8'd1;
        checkOutput("clrmis", 1'b1, 1'b1, 16'd0, mExp);
        checkVal("clrmis err_cnt4", 32'(errCnt4), 32'd0);
        applyStimulus(1'b1, mExp, 1'b0);
        mExp = mExp + 8'd1;
        checkOutput("afterclr", 1'b1, 1'b0, 16'd0, mExp);

        // Asynchronous reset mid-LOCK, asserted between clock edges.
        applyStimulus(1'b1, mExp + 8'd9, 1'b0);
        mExp = mExp + 8'd1;
        checkOutput("prerst", 1'b1, 1'b1, 16'd1, mExp);
        inValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncrst", 1'b0, 1'b0, 16'd0, 8'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'd40, 1'b0);
        checkOutput("reseed", 1'b0, 1'b0, 16'd0, 8'd41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
